ahbl_to_apb_bridge: RTL and testbench

//  AHB-Lite slave to APB4 master bridge. Hangs off one dst_* slave port of the AHB-Lite crossbar.

---
 rtl/ahbl_to_apb_bridge_pkg.sv | 45 ++++
 rtl/ahbl_to_apb_bridge.sv | 125 ++++++++++++
 tb/tb_ahbl_to_apb_bridge.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahbl_to_apb_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_to_apb_bridge_pkg
// Description : Shared AHB-Lite codes, bridge FSM state type and the APB
//               byte-strobe decode used by the AHB-Lite to APB4 bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package ahbl_to_apb_bridge_pkg;

    // AHB-Lite transfer type codes
    localparam logic [1:0] c_htrans_idle = 2'd0;
    localparam logic [1:0] c_htrans_busy = 2'd1;
    localparam logic [1:0] c_htrans_nseq = 2'd2;
    localparam logic [1:0] c_htrans_seq  = 2'd3;

    // AHB-Lite transfer size codes
    localparam logic [2:0] c_hsize_byte = 3'd0;
    localparam logic [2:0] c_hsize_half = 3'd1;
    localparam logic [2:0] c_hsize_word = 3'd2;

    // Bridge FSM states, explicitly encoded
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } bridge_state_t;

    // Byte-lane strobes for a write; anything wider than a word enables all lanes
    function automatic logic [3:0] calc_pstrb(input logic [2:0] hsize,
                                              input logic [1:0] addr_lo);
        logic [3:0] strb;
        strb = 4'b1111;
        case (hsize)
            c_hsize_byte: strb = 4'b0001 << addr_lo;
            c_hsize_half: strb = 4'b0011 << {addr_lo[1], 1'b0};
            c_hsize_word: strb = 4'b1111;
            default:      strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahbl_to_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ahbl_to_apb_bridge
// Description : AHB-Lite slave to APB4 master bridge. Each AHB beat becomes
//               one APB SETUP/ACCESS sequence; the AHB data phase is stalled
//               until the completer answers, and pslverr becomes the two-cycle
//               AHB ERROR response.
// Revision    : 1.0 - initial release
// ============================================================================
module ahbl_to_apb_bridge
    import ahbl_to_apb_bridge_pkg::*;
#(
    parameter int W_HADDR = 32,
    parameter int W_PADDR = 16,
    parameter int W_DATA  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ahbls_hready,
    output logic               ahbls_hready_resp,
    output logic               ahbls_hresp,
    input  logic [W_HADDR-1:0] ahbls_haddr,
    input  logic               ahbls_hwrite,
    input  logic [1:0]         ahbls_htrans,
    input  logic [2:0]         ahbls_hsize,
    input  logic [2:0]         ahbls_hburst,
    input  logic [3:0]         ahbls_hprot,
    input  logic               ahbls_hmastlock,
    input  logic [W_DATA-1:0]  ahbls_hwdata,
    output logic [W_DATA-1:0]  ahbls_hrdata,
    output logic [W_PADDR-1:0] apbm_paddr,
    output logic               apbm_psel,
    output logic               apbm_penable,
    output logic               apbm_pwrite,
    output logic [W_DATA-1:0]  apbm_pwdata,
    output logic [3:0]         apbm_pstrb,
    input  logic               apbm_pready,
    input  logic [W_DATA-1:0]  apbm_prdata,
    input  logic               apbm_pslverr
);

    bridge_state_t      r_state;
    logic [W_DATA-1:0]  r_hrdata;
    logic [W_PADDR-1:0] r_paddr;
    logic               r_pwrite;
    logic [3:0]         r_pstrb;

    logic w_active;
    logic w_accept;

    // Burst attributes, protection, lock and the upper address bits play no
    // part in an APB access; every beat is an independent transfer.
    logic w_unused_ok;
    assign w_unused_ok = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock,
                           ahbls_haddr[W_HADDR-1:W_PADDR]};

    // A new beat may only be taken while the AHB side is not being stalled
    assign w_active = (ahbls_htrans == c_htrans_nseq) || (ahbls_htrans == c_htrans_seq);
    assign w_accept = ahbls_hready && w_active &&
                      ((r_state == ST_IDLE) || (r_state == ST_ERR2));

    // Bridge sequencer: state, captured address-phase controls and read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_hrdata <= '0;
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pstrb  <= 4'b0000;
        end else begin
            if (w_accept) begin
                r_paddr  <= ahbls_haddr[W_PADDR-1:0];
                r_pwrite <= ahbls_hwrite;
                r_pstrb  <= ahbls_hwrite ? calc_pstrb(ahbls_hsize, ahbls_haddr[1:0]) : 4'b0000;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (apbm_pready) begin
                        if (apbm_pslverr) begin
                            r_state <= ST_ERR1;
                        end else begin
                            r_state <= ST_IDLE;
                            if (!r_pwrite) begin
                                r_hrdata <= apbm_prdata;
                            end
                        end
                    end
                end
                ST_ERR1: begin
                    r_state <= ST_ERR2;
                end
                ST_ERR2: begin
                    r_state <= w_accept ? ST_SETUP : ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode the registered state only, so no AHB input
    // reaches an AHB output combinationally.
    assign ahbls_hready_resp = (r_state == ST_IDLE) || (r_state == ST_ERR2);
    assign ahbls_hresp       = (r_state == ST_ERR1) || (r_state == ST_ERR2);
    assign apbm_psel         = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign apbm_penable      = (r_state == ST_ACCESS);

    // The AHB master holds write data stable through a stalled data phase
    assign apbm_pwdata  = ahbls_hwdata;
    assign ahbls_hrdata = r_hrdata;
    assign apbm_paddr   = r_paddr;
    assign apbm_pwrite  = r_pwrite;
    assign apbm_pstrb   = r_pstrb;

endmodule
`default_nettype wire

// File: tb/tb_ahbl_to_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahbl_to_apb_bridge
// Description : Self-checking bench for the AHB-Lite to APB4 bridge. Directed
//               scenarios followed by randomized single transfers, each checked
//               cycle by cycle against a transaction-level expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahbl_to_apb_bridge;

    logic        clk;
    logic        rst;
    logic        ahbls_hready;
    logic        ahbls_hready_resp;
    logic        ahbls_hresp;
    logic [31:0] ahbls_haddr;
    logic        ahbls_hwrite;
    logic [1:0]  ahbls_htrans;
    logic [2:0]  ahbls_hsize;
    logic [2:0]  ahbls_hburst;
    logic [3:0]  ahbls_hprot;
    logic        ahbls_hmastlock;
    logic [31:0] ahbls_hwdata;
    logic [31:0] ahbls_hrdata;
    logic [15:0] apbm_paddr;
    logic        apbm_psel;
    logic        apbm_penable;
    logic        apbm_pwrite;
    logic [31:0] apbm_pwdata;
    logic [3:0]  apbm_pstrb;
    logic        apbm_pready;
    logic [31:0] apbm_prdata;
    logic        apbm_pslverr;

    int n_cmp;
    int n_err;

    // Reference state: last successfully read data and the last accepted controls
    logic [31:0] exp_hrdata;
    logic [15:0] exp_paddr;
    logic        exp_pwrite;
    logic [3:0]  exp_pstrb;

    ahbl_to_apb_bridge #(
        .W_HADDR(32),
        .W_PADDR(16),
        .W_DATA (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ahbls_hready     (ahbls_hready),
        .ahbls_hready_resp(ahbls_hready_resp),
        .ahbls_hresp      (ahbls_hresp),
        .ahbls_haddr      (ahbls_haddr),
        .ahbls_hwrite     (ahbls_hwrite),
        .ahbls_htrans     (ahbls_htrans),
        .ahbls_hsize      (ahbls_hsize),
        .ahbls_hburst     (ahbls_hburst),
        .ahbls_hprot      (ahbls_hprot),
        .ahbls_hmastlock  (ahbls_hmastlock),
        .ahbls_hwdata     (ahbls_hwdata),
        .ahbls_hrdata     (ahbls_hrdata),
        .apbm_paddr       (apbm_paddr),
        .apbm_psel        (apbm_psel),
        .apbm_penable     (apbm_penable),
        .apbm_pwrite      (apbm_pwrite),
        .apbm_pwdata      (apbm_pwdata),
        .apbm_pstrb       (apbm_pstrb),
        .apbm_pready      (apbm_pready),
        .apbm_prdata      (apbm_prdata),
        .apbm_pslverr     (apbm_pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Strobe pattern from the byte-lane rules, computed arithmetically
    function automatic logic [3:0] model_strb(input logic wr, input logic [2:0] sz,
                                              input logic [31:0] addr);
        int lane;
        lane = int'(addr % 4);
        if (!wr)          return 4'b0000;
        if (sz == 3'd0)   return 4'(1 << lane);
        if (sz == 3'd1)   return 4'(3 << (lane & 2));
        return 4'b1111;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_psel"},    32'(apbm_psel),         32'd0);
        chk({tag, "_penable"}, 32'(apbm_penable),      32'd0);
        chk({tag, "_hready"},  32'(ahbls_hready_resp), 32'd1);
        chk({tag, "_hresp"},   32'(ahbls_hresp),       32'd0);
    endtask

    // One AHB beat: address phase presented in the current cycle, returns in the
    // first cycle where the bridge again shows hready_resp=1 (OKAY or ERR second cycle).
    task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] sz,
                           input logic [31:0] wdata, input int waits, input logic err,
                           input logic [31:0] rdata);
        chk("aph_hready_resp", 32'(ahbls_hready_resp), 32'd1);
        ahbls_haddr     = addr;
        ahbls_hwrite    = wr;
        ahbls_hsize     = sz;
        ahbls_htrans    = 2'd2;
        ahbls_hready    = 1'b1;
        ahbls_hburst    = 3'($urandom);
        ahbls_hprot     = 4'($urandom);
        ahbls_hmastlock = 1'($urandom);
        exp_paddr  = addr[15:0];
        exp_pwrite = wr;
        exp_pstrb  = model_strb(wr, sz, addr);
        step();
        // SETUP cycle: pready/pslverr are don't-care here
        ahbls_htrans = 2'd0;
        ahbls_haddr  = $urandom;
        ahbls_hwdata = wdata;
        apbm_pready  = 1'($urandom);
        apbm_pslverr = 1'($urandom);
        apbm_prdata  = $urandom;
        chk("setup_psel",    32'(apbm_psel),         32'd1);
        chk("setup_penable", 32'(apbm_penable),      32'd0);
        chk("setup_hready",  32'(ahbls_hready_resp), 32'd0);
        chk("setup_paddr",   32'(apbm_paddr),        32'(exp_paddr));
        chk("setup_pwrite",  32'(apbm_pwrite),       32'(exp_pwrite));
        chk("setup_pstrb",   32'(apbm_pstrb),        32'(exp_pstrb));
        step();
        for (int k = 0; k <= waits; k++) begin
            chk("access_psel",    32'(apbm_psel),         32'd1);
            chk("access_penable", 32'(apbm_penable),      32'd1);
            chk("access_hready",  32'(ahbls_hready_resp), 32'd0);
            chk("access_hresp",   32'(ahbls_hresp),       32'd0);
            if (wr) chk("access_pwdata", apbm_pwdata, wdata);
            apbm_pready  = (k == waits);
            apbm_pslverr = (k == waits) ? err : 1'($urandom);
            apbm_prdata  = (k == waits) ? rdata : $urandom;
            step();
        end
        apbm_pready  = 1'b0;
        apbm_pslverr = 1'b0;
        if (!err) begin
            if (!wr) exp_hrdata = rdata;
            chk("done_hready", 32'(ahbls_hready_resp), 32'd1);
            chk("done_hresp",  32'(ahbls_hresp),       32'd0);
            chk("done_psel",   32'(apbm_psel),         32'd0);
            chk("done_hrdata", ahbls_hrdata,           exp_hrdata);
        end else begin
            chk("err1_hready", 32'(ahbls_hready_resp), 32'd0);
            chk("err1_hresp",  32'(ahbls_hresp),       32'd1);
            chk("err1_psel",   32'(apbm_psel),         32'd0);
            step();
            chk("err2_hready", 32'(ahbls_hready_resp), 32'd1);
            chk("err2_hresp",  32'(ahbls_hresp),       32'd1);
            chk("err2_hrdata", ahbls_hrdata,           exp_hrdata);
        end
        chk("hold_paddr",  32'(apbm_paddr),  32'(exp_paddr));
        chk("hold_pwrite", 32'(apbm_pwrite), 32'(exp_pwrite));
        chk("hold_pstrb",  32'(apbm_pstrb),  32'(exp_pstrb));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        ahbls_hready = 1'b1;  ahbls_haddr = '0;   ahbls_hwrite = 1'b0;
        ahbls_htrans = 2'd0;  ahbls_hsize = 3'd2; ahbls_hburst = 3'd0;
        ahbls_hprot = 4'd0;   ahbls_hmastlock = 1'b0; ahbls_hwdata = '0;
        apbm_pready = 1'b0;   apbm_prdata = '0;   apbm_pslverr = 1'b0;
        exp_hrdata = '0; exp_paddr = '0; exp_pwrite = 1'b0; exp_pstrb = 4'b0000;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check_idle("reset");
        chk("reset_hrdata", ahbls_hrdata,      32'd0);
        chk("reset_paddr",  32'(apbm_paddr),   32'd0);
        chk("reset_pwrite", 32'(apbm_pwrite),  32'd0);
        chk("reset_pstrb",  32'(apbm_pstrb),   32'd0);

        // Zero-wait read: psel at N+1, penable at N+2, data with hready at N+3
        do_xfer(32'h0000_1234, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'hCAFE_F00D);
        chk("t1_hrdata", ahbls_hrdata, 32'hCAFE_F00D);
        step();
        check_idle("t1_idle");

        // Byte write to lane 3 with three APB wait states
        do_xfer(32'h4000_0003, 1'b1, 3'd0, 32'hAA00_0000, 3, 1'b0, 32'h0);
        chk("t2_pstrb", 32'(apbm_pstrb), 32'h8);
        step();
        check_idle("t2_idle");

        // Write answered with pslverr: two-cycle ERROR, then OKAY idle
        do_xfer(32'h0000_0100, 1'b1, 3'd2, 32'h1234_5678, 1, 1'b1, 32'h0);
        step();
        check_idle("t3_idle");

        // Back-to-back reads: second address phase in the first one's completion cycle
        do_xfer(32'h0000_0200, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h1111_2222);
        do_xfer(32'h0000_0204, 1'b0, 3'd2, 32'h0, 1, 1'b0, 32'h3333_4444);
        step();
        check_idle("t4_idle");

        // BUSY is never accepted; NSEQ with hready low is never accepted
        ahbls_htrans = 2'd1;
        ahbls_hready = 1'b1;
        step();
        check_idle("t5_busy");
        ahbls_htrans = 2'd2;
        ahbls_hready = 1'b0;
        step();
        check_idle("t5_nohready");
        ahbls_htrans = 2'd0;
        ahbls_hready = 1'b1;
        step();
        check_idle("t5_after");

        // Reset arriving mid-ACCESS abandons the transfer
        ahbls_haddr  = 32'h0000_0ABC;
        ahbls_hwrite = 1'b1;
        ahbls_hsize  = 3'd1;
        ahbls_htrans = 2'd2;
        step();
        ahbls_htrans = 2'd0;
        step();
        chk("t6_in_access", 32'(apbm_penable), 32'd1);
        apbm_pready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("t6_reset");
        chk("t6_hrdata", ahbls_hrdata,     32'd0);
        chk("t6_paddr",  32'(apbm_paddr),  32'd0);
        chk("t6_pstrb",  32'(apbm_pstrb),  32'd0);
        exp_hrdata = '0;

        // Randomized beats, including back-to-back, errors, odd sizes and accept in ERR2
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic        w;
            logic [2:0]  s;
            logic        e;
            a = $urandom;
            w = 1'($urandom);
            s = 3'($urandom_range(0, 7));
            e = ($urandom_range(0, 4) == 0);
            do_xfer(a, w, s, $urandom, int'($urandom_range(0, 3)), e, $urandom);
            if ($urandom_range(0, 2) == 0) begin
                step();
                check_idle("rnd_idle");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
